watch_clock_v2: RTL and testbench
=================================

WATCH_CLOCK_V2 -- requirements
Module: watch_clock_v2

Interface
REQ-001 SHALL have parameters (name, default, meaning): P_COUNT_BIT, 30, prescaler/i_freq width.
REQ-002 SHALL have P_SEC_BIT, 6, seconds width; P_MIN_BIT, 6, minutes width; P_HOUR_BIT, 5, hours width.
REQ-003 SHALL have P_SEC_MAX, 60, seconds modulus; P_MIN_MAX, 60, minutes modulus; P_HOUR_MAX, 24, hours modulus.
REQ-004 SHALL have ports (name, direction, width, meaning): clk, in, 1, single clock; reset, in, 1, synchronous active-high reset.
REQ-005 i_run_en, in, 1, count enable; i_freq, in, P_COUNT_BIT, clk cycles per second.
REQ-006 i_load, in, 1, time-load strobe; i_load_sec / i_load_min / i_load_hour, in, P_SEC_BIT / P_MIN_BIT / P_HOUR_BIT, load values.
REQ-007 i_mode_12h, in, 1, 1 = 12-hour display; i_alarm_set, in, 1, alarm-load strobe; i_alarm_min / i_alarm_hour, in, P_MIN_BIT / P_HOUR_BIT, alarm time (24 h); i_alarm_ack, in, 1, alarm clear.
REQ-008 o_sec / o_min / o_hour, out, P_SEC_BIT / P_MIN_BIT / P_HOUR_BIT, displayed time; o_pm, out, 1, PM flag; o_day_tick, out, 1, rollover pulse; o_load_err, out, 1, rejected-load pulse; o_alarm, out, 1, alarm flag.

Function
REQ-009 Prescaler SHALL count 0..i_freq-1 while i_run_en=1, issuing one internal tick on the cycle it equals i_freq-1, then wrapping to 0; i_freq of 0 or 1 SHALL tick every enabled cycle.
REQ-010 i_run_en=0 SHALL freeze prescaler and time; no ticks.
REQ-011 Time SHALL be held as cascaded counters sec, min, hour (24-h internal, 0..P_HOUR_MAX-1); no division or modulo operators.
REQ-012 On tick: sec+1; sec at P_SEC_MAX-1 wraps to 0 and carries to min; min at P_MIN_MAX-1 wraps and carries to hour; hour at P_HOUR_MAX-1 wraps to 0.
REQ-013 On the full wrap (P_HOUR_MAX-1:P_MIN_MAX-1:P_SEC_MAX-1 to 0:0:0) o_day_tick SHALL pulse high exactly one cycle, aligned with outputs showing 0:0:0.
REQ-014 Outputs SHALL be registered; the tick cycle's update SHALL appear on outputs the following cycle (latency 1).
REQ-015 i_mode_12h=0: o_hour = internal hour, o_pm=0; i_mode_12h=1: o_hour = 12 for hours 0 and 12, else hour mod 12; o_pm=1 for hour>=12; mode change SHALL take effect on the next cycle without altering internal time.
REQ-016 i_load=1 with all values in range (< respective MAX) SHALL load internal time and clear the prescaler; outputs reflect it next cycle.
REQ-017 i_load=1 with any value out of range SHALL leave time unchanged and pulse o_load_err for one cycle.
REQ-018 i_load and a tick in the same cycle: load wins, tick discarded; no o_day_tick from that cycle.
REQ-019 i_load SHALL act regardless of i_run_en.

Reset
REQ-020 reset=1 at a clk edge SHALL clear prescaler, internal time, stored alarm, o_sec, o_min, o_hour (0; 12 if i_mode_12h=1 the cycle after release), o_pm, o_day_tick, o_load_err, o_alarm to 0, with priority over all other inputs, including mid-count.

Configuration
REQ-021 Macro WATCH_ALARM_EN SHALL compile the alarm feature in.
REQ-022 With WATCH_ALARM_EN: i_alarm_set stores i_alarm_hour/i_alarm_min (out-of-range values pulse o_load_err, not stored) and arms the alarm; o_alarm SHALL set when time advances by tick to alarm_hour:alarm_min:00, stays high until i_alarm_ack; a match in the same cycle as ack SHALL leave o_alarm=1; a time load never sets o_alarm.
REQ-023 Without WATCH_ALARM_EN: no alarm storage logic; o_alarm tied 0; alarm inputs ignored.

Verification
REQ-024 reset, i_freq=4, i_run_en=1 for 40 cycles -> o_sec=10, o_min=0, o_hour=0; ticks every 4th cycle.
REQ-025 Load 23:59:58 (i_freq=1), two ticks -> 0:0:0, o_day_tick one-cycle pulse on that output cycle.
REQ-026 Load 13:05:00, i_mode_12h=1 -> o_hour=1, o_pm=1; load 0:00:00 -> o_hour=12, o_pm=0.
REQ-027 Load with i_load_min=60 -> o_load_err one pulse, time unchanged; i_load on a tick cycle -> loaded value, no increment.
REQ-028 WATCH_ALARM_EN, alarm 7:30, load 7:29:59, one tick -> o_alarm=1; holds until i_alarm_ack; reset mid-count -> all outputs 0.

Source files
------------

// File: rtl/watch_clock_v2.sv
// Watch clock: prescaled seconds tick driving sec/min/hour counters with 12/24-hour display.
// Define WATCH_ALARM_EN to build in the hour:minute alarm.
module watch_clock_v2 #(
  parameter int unsigned P_COUNT_BIT = 30,
  parameter int unsigned P_SEC_BIT   = 6,
  parameter int unsigned P_MIN_BIT   = 6,
  parameter int unsigned P_HOUR_BIT  = 5,
  parameter int unsigned P_SEC_MAX   = 60,
  parameter int unsigned P_MIN_MAX   = 60,
  parameter int unsigned P_HOUR_MAX  = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_run_en,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  input  logic                   i_load,
  input  logic [P_SEC_BIT-1:0]   i_load_sec,
  input  logic [P_MIN_BIT-1:0]   i_load_min,
  input  logic [P_HOUR_BIT-1:0]  i_load_hour,
  input  logic                   i_mode_12h,
  input  logic                   i_alarm_set,
  input  logic [P_MIN_BIT-1:0]   i_alarm_min,
  input  logic [P_HOUR_BIT-1:0]  i_alarm_hour,
  input  logic                   i_alarm_ack,
  output logic [P_SEC_BIT-1:0]   o_sec,
  output logic [P_MIN_BIT-1:0]   o_min,
  output logic [P_HOUR_BIT-1:0]  o_hour,
  output logic                   o_pm,
  output logic                   o_day_tick,
  output logic                   o_load_err,
  output logic                   o_alarm
);

  localparam logic [P_SEC_BIT-1:0]   SEC_LAST   = P_SEC_BIT'(P_SEC_MAX - 1);
  localparam logic [P_MIN_BIT-1:0]   MIN_LAST   = P_MIN_BIT'(P_MIN_MAX - 1);
  localparam logic [P_HOUR_BIT-1:0]  HOUR_LAST  = P_HOUR_BIT'(P_HOUR_MAX - 1);
  localparam logic [P_HOUR_BIT-1:0]  HOUR_NOON  = P_HOUR_BIT'(12);
  localparam logic [P_COUNT_BIT-1:0] CNT_ONE    = P_COUNT_BIT'(1);

  logic [P_COUNT_BIT-1:0] cnt_q, cnt_d;
  logic [P_SEC_BIT-1:0]   sec_q, sec_d, sec_out_q, sec_out_d;
  logic [P_MIN_BIT-1:0]   min_q, min_d, min_out_q, min_out_d;
  logic [P_HOUR_BIT-1:0]  hour_q, hour_d, hour_out_q, hour_out_d;
  logic                   pm_q, pm_d;
  logic                   day_tick_q, day_tick_d;
  logic                   load_err_q, load_err_d;
  logic                   tick_c, adv_c, load_ok_c, alarm_err_c;

  // Prescaler tick; >= keeps the count bounded if i_freq shrinks mid-count.
  always_comb begin
    tick_c    = i_run_en && ((i_freq <= CNT_ONE) || (cnt_q >= (i_freq - CNT_ONE)));
    adv_c     = tick_c && !i_load;
    load_ok_c = (i_load_sec <= SEC_LAST) && (i_load_min <= MIN_LAST) &&
                (i_load_hour <= HOUR_LAST);
  end

  // Next time state: cascaded counters, load overrides any tick.
  always_comb begin
    cnt_d      = cnt_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    day_tick_d = 1'b0;
    if (i_run_en) begin
      cnt_d = tick_c ? '0 : cnt_q + CNT_ONE;
    end
    if (adv_c) begin
      if (sec_q == SEC_LAST) begin
        sec_d = '0;
        if (min_q == MIN_LAST) begin
          min_d = '0;
          if (hour_q == HOUR_LAST) begin
            hour_d     = '0;
            day_tick_d = 1'b1;
          end else begin
            hour_d = hour_q + P_HOUR_BIT'(1);
          end
        end else begin
          min_d = min_q + P_MIN_BIT'(1);
        end
      end else begin
        sec_d = sec_q + P_SEC_BIT'(1);
      end
    end
    if (i_load && load_ok_c) begin
      cnt_d  = '0;
      sec_d  = i_load_sec;
      min_d  = i_load_min;
      hour_d = i_load_hour;
    end
    load_err_d = (i_load && !load_ok_c) || alarm_err_c;
  end

  // Display conversion from the next internal time so outputs trail by one cycle.
  always_comb begin
    sec_out_d  = sec_d;
    min_out_d  = min_d;
    hour_out_d = hour_d;
    pm_d       = 1'b0;
    if (i_mode_12h) begin
      pm_d = (hour_d >= HOUR_NOON);
      if (hour_d == '0) begin
        hour_out_d = HOUR_NOON;
      end else if (hour_d > HOUR_NOON) begin
        hour_out_d = hour_d - HOUR_NOON;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      sec_out_q  <= '0;
      min_out_q  <= '0;
      hour_out_q <= '0;
      pm_q       <= 1'b0;
      day_tick_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      sec_out_q  <= sec_out_d;
      min_out_q  <= min_out_d;
      hour_out_q <= hour_out_d;
      pm_q       <= pm_d;
      day_tick_q <= day_tick_d;
      load_err_q <= load_err_d;
    end
  end

  assign o_sec      = sec_out_q;
  assign o_min      = min_out_q;
  assign o_hour     = hour_out_q;
  assign o_pm       = pm_q;
  assign o_day_tick = day_tick_q;
  assign o_load_err = load_err_q;

`ifdef WATCH_ALARM_EN
  logic [P_MIN_BIT-1:0]  alarm_min_q, alarm_min_d;
  logic [P_HOUR_BIT-1:0] alarm_hour_q, alarm_hour_d;
  logic                  armed_q, armed_d;
  logic                  alarm_q, alarm_d;
  logic                  alarm_ok_c, match_c;

  // Alarm fires only on a tick that lands on hh:mm:00; a set can pulse o_load_err.
  always_comb begin
    alarm_ok_c   = (i_alarm_min <= MIN_LAST) && (i_alarm_hour <= HOUR_LAST);
    alarm_err_c  = i_alarm_set && !alarm_ok_c;
    alarm_min_d  = alarm_min_q;
    alarm_hour_d = alarm_hour_q;
    armed_d      = armed_q;
    if (i_alarm_set && alarm_ok_c) begin
      alarm_min_d  = i_alarm_min;
      alarm_hour_d = i_alarm_hour;
      armed_d      = 1'b1;
    end
    match_c = adv_c && armed_q && (sec_d == '0) && (min_d == alarm_min_q) &&
              (hour_d == alarm_hour_q);
    alarm_d = alarm_q;
    if (match_c) begin
      alarm_d = 1'b1;
    end else if (i_alarm_ack) begin
      alarm_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_min_q  <= '0;
      alarm_hour_q <= '0;
      armed_q      <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      alarm_min_q  <= alarm_min_d;
      alarm_hour_q <= alarm_hour_d;
      armed_q      <= armed_d;
      alarm_q      <= alarm_d;
    end
  end

  assign o_alarm = alarm_q;
`else
  logic unused_alarm_in;
  assign unused_alarm_in = &{1'b0, i_alarm_set, i_alarm_min, i_alarm_hour, i_alarm_ack};
  assign alarm_err_c     = 1'b0;
  assign o_alarm         = 1'b0;
`endif

endmodule

// File: tb/tb_watch_clock_v2.sv
// Directed self-checking bench for watch_clock_v2: load/display table plus tick, wrap, load and reset sequences.
module tb_watch_clock_v2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_run_en;
  logic [29:0] i_freq;
  logic        i_load;
  logic [5:0]  i_load_sec, i_load_min;
  logic [4:0]  i_load_hour;
  logic        i_mode_12h, i_alarm_set, i_alarm_ack;
  logic [5:0]  i_alarm_min;
  logic [4:0]  i_alarm_hour;
  logic [5:0]  o_sec, o_min;
  logic [4:0]  o_hour;
  logic        o_pm, o_day_tick, o_load_err, o_alarm;

  int n_cmp = 0;
  int n_err = 0;

  watch_clock_v2 dut (
    .clk(clk), .reset(reset), .i_run_en(i_run_en), .i_freq(i_freq),
    .i_load(i_load), .i_load_sec(i_load_sec), .i_load_min(i_load_min),
    .i_load_hour(i_load_hour), .i_mode_12h(i_mode_12h), .i_alarm_set(i_alarm_set),
    .i_alarm_min(i_alarm_min), .i_alarm_hour(i_alarm_hour), .i_alarm_ack(i_alarm_ack),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_pm(o_pm),
    .o_day_tick(o_day_tick), .o_load_err(o_load_err), .o_alarm(o_alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h, m, s, mode;
    int eh, em, es, epm, eerr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s);
    chk({name, ".hour"}, int'(o_hour), h);
    chk({name, ".min"}, int'(o_min), m);
    chk({name, ".sec"}, int'(o_sec), s);
  endtask

  task automatic set_load(input int h, input int m, input int s);
    i_load      = 1'b1;
    i_load_hour = 5'(h);
    i_load_min  = 6'(m);
    i_load_sec  = 6'(s);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{h:13, m:5,  s:0,  mode:1, eh:1,  em:5,  es:0,  epm:1, eerr:0};
    tbl[1] = '{h:0,  m:0,  s:0,  mode:1, eh:12, em:0,  es:0,  epm:0, eerr:0};
    tbl[2] = '{h:12, m:0,  s:0,  mode:1, eh:12, em:0,  es:0,  epm:1, eerr:0};
    tbl[3] = '{h:23, m:59, s:59, mode:1, eh:11, em:59, es:59, epm:1, eerr:0};
    tbl[4] = '{h:11, m:30, s:15, mode:1, eh:11, em:30, es:15, epm:0, eerr:0};
    tbl[5] = '{h:13, m:5,  s:0,  mode:0, eh:13, em:5,  es:0,  epm:0, eerr:0};
    tbl[6] = '{h:10, m:60, s:0,  mode:0, eh:13, em:5,  es:0,  epm:0, eerr:1};
    tbl[7] = '{h:24, m:0,  s:0,  mode:1, eh:1,  em:5,  es:0,  epm:1, eerr:1};
    tbl[8] = '{h:3,  m:4,  s:60, mode:0, eh:13, em:5,  es:0,  epm:0, eerr:1};
    tbl[9] = '{h:1,  m:0,  s:0,  mode:0, eh:1,  em:0,  es:0,  epm:0, eerr:0};

    reset = 1'b1; i_run_en = 1'b0; i_freq = 30'd4; i_load = 1'b0;
    i_load_sec = '0; i_load_min = '0; i_load_hour = '0; i_mode_12h = 1'b0;
    i_alarm_set = 1'b0; i_alarm_min = '0; i_alarm_hour = '0; i_alarm_ack = 1'b0;

    // Reset state
    step(2);
    chk_time("rst", 0, 0, 0);
    chk("rst.pm", int'(o_pm), 0);
    chk("rst.day", int'(o_day_tick), 0);
    chk("rst.err", int'(o_load_err), 0);
    chk("rst.alarm", int'(o_alarm), 0);

    // Prescaler of 4: first tick appears after the 4th edge, 10 s after 40
    reset = 1'b0; i_run_en = 1'b1; i_freq = 30'd4;
    step(3);
    chk("pre3.sec", int'(o_sec), 0);
    step(1);
    chk("pre4.sec", int'(o_sec), 1);
    step(36);
    chk_time("pre40", 0, 0, 10);

    // Load/display table, clock frozen
    i_run_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_load(tbl[i].h, tbl[i].m, tbl[i].s);
      i_mode_12h = tbl[i].mode[0];
      step(1);
      i_load = 1'b0;
      chk_time($sformatf("tbl%0d", i), tbl[i].eh, tbl[i].em, tbl[i].es);
      chk($sformatf("tbl%0d.pm", i), int'(o_pm), tbl[i].epm);
      chk($sformatf("tbl%0d.err", i), int'(o_load_err), tbl[i].eerr);
      step(1);
      chk($sformatf("tbl%0d.err_clr", i), int'(o_load_err), 0);
    end

    // Day rollover with i_freq=1
    i_mode_12h = 1'b0; i_freq = 30'd1;
    set_load(23, 59, 58);
    step(1);
    i_load = 1'b0; i_run_en = 1'b1;
    step(1);
    chk_time("wrap1", 23, 59, 59);
    chk("wrap1.day", int'(o_day_tick), 0);
    step(1);
    chk_time("wrap2", 0, 0, 0);
    chk("wrap2.day", int'(o_day_tick), 1);
    step(1);
    chk_time("wrap3", 0, 0, 1);
    chk("wrap3.day", int'(o_day_tick), 0);

    // Load on a tick cycle wins, including over a would-be day wrap
    set_load(5, 6, 7);
    step(1);
    chk_time("ldtick", 5, 6, 7);
    i_load = 1'b0;
    step(1);
    chk_time("ldtick.next", 5, 6, 8);
    set_load(23, 59, 59);
    step(1);
    set_load(1, 0, 0);
    step(1);
    chk_time("ldwrap", 1, 0, 0);
    chk("ldwrap.day", int'(o_day_tick), 0);

    // Freeze
    i_load = 1'b0; i_run_en = 1'b0;
    step(5);
    chk_time("freeze", 1, 0, 0);

    // Load while frozen at a 12h-visible hour, mode toggles do not disturb time
    set_load(15, 20, 30);
    step(1);
    i_load = 1'b0; i_mode_12h = 1'b1;
    step(1);
    chk("mode12.hour", int'(o_hour), 3);
    chk("mode12.pm", int'(o_pm), 1);
    i_mode_12h = 1'b0;
    step(1);
    chk_time("mode24", 15, 20, 30);

`ifdef WATCH_ALARM_EN
    i_alarm_set = 1'b1; i_alarm_hour = 5'd7; i_alarm_min = 6'd30;
    step(1);
    chk("alset.err", int'(o_load_err), 0);
    i_alarm_min = 6'd61;
    step(1);
    i_alarm_set = 1'b0;
    chk("alset_bad.err", int'(o_load_err), 1);
    set_load(7, 30, 0);
    step(1);
    chk("alload.alarm", int'(o_alarm), 0);
    set_load(7, 29, 59);
    step(1);
    i_load = 1'b0; i_run_en = 1'b1;
    step(1);
    i_run_en = 1'b0;
    chk("alfire.alarm", int'(o_alarm), 1);
    step(3);
    chk("alhold.alarm", int'(o_alarm), 1);
    i_alarm_ack = 1'b1;
    step(1);
    chk("alack.alarm", int'(o_alarm), 0);
    set_load(7, 29, 59);
    step(1);
    i_load = 1'b0; i_run_en = 1'b1;
    step(1);
    chk("alack_match.alarm", int'(o_alarm), 1);
    i_run_en = 1'b0;
    step(1);
    chk("alack2.alarm", int'(o_alarm), 0);
    i_alarm_ack = 1'b0;
`else
    i_alarm_set = 1'b1; i_alarm_hour = 5'd7; i_alarm_min = 6'd30;
    set_load(7, 29, 59);
    step(1);
    i_alarm_set = 1'b0; i_load = 1'b0; i_run_en = 1'b1;
    step(1);
    i_run_en = 1'b0;
    chk_time("noal", 7, 30, 0);
    chk("noal.alarm", int'(o_alarm), 0);
`endif

    // Mid-count reset, then release in 12h mode
    set_load(9, 9, 9);
    step(1);
    i_load = 1'b0; i_freq = 30'd4; i_run_en = 1'b1;
    step(2);
    reset = 1'b1; i_mode_12h = 1'b1;
    step(1);
    chk_time("midrst", 0, 0, 0);
    chk("midrst.pm", int'(o_pm), 0);
    chk("midrst.alarm", int'(o_alarm), 0);
    reset = 1'b0;
    step(1);
    chk("rel.hour12", int'(o_hour), 12);
    step(2);
    chk("rel3.sec", int'(o_sec), 0);
    step(1);
    chk("rel4.sec", int'(o_sec), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
